// File: rtl/universal_shift_register_param.sv
`timescale 1ns/1ps
// universal_shift_register_param
// Parametrised universal shift register with parallel load, serial fill and
// serial outputs, plus a multi-position shift sequencer that applies COUNT
// single-bit shifts (one per enabled clock) with a busy/done handshake.
module universal_shift_register_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             ser_in_left,
  input  logic             ser_in_right,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_left,
  output logic             ser_out_right,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ROL = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ASR = 3'b100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [2:0]       r_mode;
  logic [CNT_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_done;

  logic             w_mode_valid;
  logic             w_last_shift;
  logic [WIDTH-1:0] w_shifted;

  // Single-position shift of the current contents in the given mode.
  function automatic logic [WIDTH-1:0] f_shift(
    input logic [2:0]       f_mode,
    input logic [WIDTH-1:0] f_val,
    input logic             f_fill_left,
    input logic             f_fill_right
  );
    logic [WIDTH-1:0] v_res;
    v_res = f_val;
    case (f_mode)
      MODE_LSL: v_res = {f_val[WIDTH-2:0], f_fill_right};
      MODE_LSR: v_res = {f_fill_left, f_val[WIDTH-1:1]};
      MODE_ROL: v_res = {f_val[WIDTH-2:0], f_val[WIDTH-1]};
      MODE_ROR: v_res = {f_val[0], f_val[WIDTH-1:1]};
      MODE_ASR: v_res = {f_val[WIDTH-1], f_val[WIDTH-1:1]};
      default:  v_res = f_val;
    endcase
    return v_res;
  endfunction

  // Command decode and next shift value; serial fills are sampled live.
  always_comb begin
    w_mode_valid = (mode <= MODE_ASR);
    w_last_shift = (r_remaining == CNT_W'(1));
    w_shifted    = f_shift(r_mode, r_q, ser_in_left, ser_in_right);
  end

  // Sequencer FSM: load/start acceptance in IDLE, one shift per enabled edge in SHIFT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_q         <= '0;
      r_mode      <= MODE_LSL;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_q <= parallel_in;
          end else if (start && w_mode_valid) begin
            if (count == '0) begin
              r_done <= 1'b1;
            end else begin
              r_mode      <= mode;
              r_remaining <= count;
              r_busy      <= 1'b1;
              r_state     <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (enable) begin
            r_q         <= w_shifted;
            r_remaining <= r_remaining - CNT_W'(1);
            if (w_last_shift) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs; serial outputs track the register contents with no extra latency.
  assign q             = r_q;
  assign busy          = r_busy;
  assign done          = r_done;
  assign ser_out_left  = r_q[WIDTH-1];
  assign ser_out_right = r_q[0];

endmodule

// File: tb/tb_universal_shift_register_param.sv
`timescale 1ns/1ps
// Self-checking bench for universal_shift_register_param (WIDTH=8, CNT_W=4).
module tb_universal_shift_register_param;

  localparam int unsigned W    = 8;
  localparam int unsigned CW   = 4;
  localparam int unsigned MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          load;
  logic [W-1:0]  parallel_in;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] count;
  logic          ser_in_left;
  logic          ser_in_right;
  logic [W-1:0]  q;
  logic          ser_out_left;
  logic          ser_out_right;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  universal_shift_register_param #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .parallel_in(parallel_in), .start(start), .mode(mode), .count(count),
    .ser_in_left(ser_in_left), .ser_in_right(ser_in_right), .q(q),
    .ser_out_left(ser_out_left), .ser_out_right(ser_out_right),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       ld;
    logic [7:0] pin;
    logic       st;
    logic [2:0] md;
    logic [3:0] cnt;
    logic       sl;
    logic       sr;
    logic       en;
    logic [7:0] eq;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic ld, logic [7:0] pin, logic st, logic [2:0] md,
                              logic [3:0] cnt, logic sl, logic sr, logic en,
                              logic [7:0] eq, logic eb, logic ed);
    vec_t v;
    v.ld = ld; v.pin = pin; v.st = st; v.md = md; v.cnt = cnt;
    v.sl = sl; v.sr = sr; v.en = en; v.eq = eq; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input int unsigned eq, input bit eb, input bit ed);
    chk({nm, ".q"}, 32'(q), 32'(eq));
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
    chk({nm, ".done"}, 32'(done), 32'(ed));
    chk({nm, ".sol"}, 32'(ser_out_left), 32'((eq >> (W - 1)) & 1));
    chk({nm, ".sor"}, 32'(ser_out_right), 32'(eq & 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; start = 1'b0; mode = 3'd0; count = '0;
    parallel_in = '0; ser_in_left = 1'b0; ser_in_right = 1'b0; enable = 1'b1;
  endtask

  // Reference: one shift of an integer value, expressed with plain arithmetic.
  function automatic int unsigned ref_shift(int unsigned v, int unsigned m, bit sl, bit sr);
    case (m)
      0: return ((v << 1) | int'(sr)) & MASK;
      1: return (v >> 1) | (int'(sl) << (W - 1));
      2: return ((v << 1) | (v >> (W - 1))) & MASK;
      3: return (v >> 1) | ((v & 1) << (W - 1));
      4: return (v >> 1) | (v & (1 << (W - 1)));
      default: return v;
    endcase
  endfunction

  int unsigned m_q;
  int unsigned m_mode;
  int          m_left;
  bit          m_busy;
  bit          m_done;

  task automatic model_step();
    m_done = 1'b0;
    if (!m_busy) begin
      if (load) m_q = int'(parallel_in);
      else if (start && int'(mode) <= 4) begin
        if (count == 0) m_done = 1'b1;
        else begin
          m_busy = 1'b1; m_left = int'(count); m_mode = int'(mode);
        end
      end
    end else if (enable) begin
      m_q = ref_shift(m_q, m_mode, ser_in_left, ser_in_right);
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  int busy_cycles;

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    chk_all("reset_state", 0, 0, 0);
    @(negedge clk) reset = 1'b0;
    tick();

    // Asynchronous reset during an active command.
    load = 1'b1; parallel_in = 8'hFF; tick();
    load = 1'b0; start = 1'b1; mode = 3'd1; count = 4'd5; tick();
    start = 1'b0; tick();
    chk("pre_reset.busy", 32'(busy), 32'(1));
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0);
    @(negedge clk) reset = 1'b0;
    tick();
    chk_all("post_reset_idle", 0, 0, 0);

    // Directed vector table: inputs for one cycle, expectations after the edge.
    vt.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 0, 1, 8'hAA, 0, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 8'hAA, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h54, 0, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h54, 0, 0));
    vt.push_back(mk(1, 8'hAA, 0, 0, 0, 0, 0, 1, 8'hAA, 0, 0));
    vt.push_back(mk(0, 8'h00, 1, 3, 3, 0, 0, 1, 8'hAA, 1, 0));
    vt.push_back(mk(1, 8'h00, 1, 0, 1, 0, 0, 1, 8'h55, 1, 0));
    vt.push_back(mk(1, 8'hFF, 1, 2, 7, 0, 0, 1, 8'hAA, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h55, 0, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h55, 0, 0));
    vt.push_back(mk(1, 8'h80, 0, 0, 0, 0, 0, 1, 8'h80, 0, 0));
    vt.push_back(mk(0, 8'h00, 1, 4, 2, 0, 0, 1, 8'h80, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'hC0, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'hE0, 0, 1));
    vt.push_back(mk(0, 8'h00, 1, 1, 2, 1, 0, 1, 8'hE0, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1, 8'hF0, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 1, 8'hF8, 0, 1));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 1, 8'hF8, 0, 1));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'hF8, 0, 0));
    vt.push_back(mk(0, 8'h00, 1, 6, 3, 0, 0, 1, 8'hF8, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'hF8, 0, 0));
    vt.push_back(mk(1, 8'h3C, 0, 0, 0, 0, 0, 0, 8'h3C, 0, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 1, 0, 8'h3C, 1, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 8'h79, 0, 1));
    for (int i = 0; i < vt.size(); i++) begin
      load = vt[i].ld; parallel_in = vt[i].pin; start = vt[i].st;
      mode = vt[i].md; count = vt[i].cnt; ser_in_left = vt[i].sl;
      ser_in_right = vt[i].sr; enable = vt[i].en;
      tick();
      chk_all($sformatf("vec%0d", i), int'(vt[i].eq), vt[i].eb, vt[i].ed);
    end
    idle_inputs();

    // Rotate left with an enable pause: busy spans the pause.
    load = 1'b1; parallel_in = 8'h01; tick();
    load = 1'b0; start = 1'b1; mode = 3'd2; count = 4'd4; tick();
    start = 1'b0; mode = 3'd0; count = '0;
    chk_all("pause.E0", 32'h01, 1, 0);
    busy_cycles = 1;
    tick();
    chk_all("pause.E1", 32'h02, 1, 0);
    busy_cycles++;
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all($sformatf("pause.hold%0d", i), 32'h02, 1, 0);
      busy_cycles++;
    end
    enable = 1'b1;
    for (int i = 0; i < 10 && busy; i++) begin
      tick();
      if (busy) busy_cycles++;
    end
    chk("pause.busy_cycles", 32'(busy_cycles), 32'(6));
    chk_all("pause.final", 32'h10, 0, 1);
    tick();
    chk_all("pause.after", 32'h10, 0, 0);

    // Reset mid-command, then confirm the sequencer restarts from idle.
    start = 1'b1; mode = 3'd2; count = 4'd8; tick();
    start = 1'b0; tick();
    chk("midrst.busy_before", 32'(busy), 32'(1));
    #2 reset = 1'b1;
    #1;
    chk_all("midrst.cleared", 0, 0, 0);
    @(negedge clk) reset = 1'b0;
    tick();
    chk_all("midrst.idle", 0, 0, 0);
    start = 1'b1; mode = 3'd0; count = 4'd1; ser_in_right = 1'b1; tick();
    start = 1'b0;
    chk_all("midrst.restart", 0, 1, 0);
    tick();
    chk_all("midrst.one", 1, 0, 1);
    idle_inputs();

    // Randomised run against the behavioural model.
    reset = 1'b1; #2; reset = 1'b0;
    m_q = 0; m_mode = 0; m_left = 0; m_busy = 1'b0; m_done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      load         = ($urandom_range(0, 7) == 0);
      parallel_in  = 8'($urandom);
      start        = ($urandom_range(0, 2) == 0);
      mode         = 3'($urandom_range(0, 7));
      count        = 4'($urandom_range(0, 15));
      enable       = ($urandom_range(0, 3) != 0);
      ser_in_left  = 1'($urandom);
      ser_in_right = 1'($urandom);
      model_step();
      tick();
      chk_all($sformatf("rand%0d", i), m_q, m_busy, m_done);
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
